// File: rtl/geofence_poly.sv
// geofence_poly: loads a target and NV vertices, sorts them into a convex polygon around V0, then tests strict containment.
// Build option GEOFENCE_BOUNDARY_INSIDE_EN: a target on an edge or vertex counts as inside.
module geofence_poly #(
    parameter int NV = 6,
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          ready,
    output logic          valid,
    output logic          is_inside
);
    localparam int IW = $clog2(NV);
    localparam int CNTW = $clog2(NV + 1);
    localparam int W = 2 * CW + 3;
    localparam logic [CNTW-1:0] LASTV = CNTW'(NV - 1);
    localparam logic [CNTW-1:0] LASTS = CNTW'(NV - 2);
`ifdef GEOFENCE_BOUNDARY_INSIDE_EN
    localparam logic ZERO_OK = 1'b1;
`else
    localparam logic ZERO_OK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SORT, EVAL, DONE} stateT;
    stateT state, nextState;

    logic live;
    logic [CW-1:0] tx, ty;
    logic [CW-1:0] vx [NV];
    logic [CW-1:0] vy [NV];
    logic [CNTW-1:0] cnt, passCnt;
    logic swapped, negAll, posAll;
    logic [IW-1:0] i0, i1;
    logic atLast, sorting, passEnd, again, swapNow, eNeg, eZero, nNeg, nPos;
    logic [CW-1:0] q1x, q1y, q2x, q2y;
    logic [CW:0] ax, ay, bx, by;
    logic [W-1:0] axe, aye, bxe, bye, cr;

    // One shared cross-product unit: SORT compares V[i]-V0 with V[i+1]-V0, EVAL uses V[k]-T with V[k+1]-V[k].
    always_comb begin
        sorting = state == SORT;
        atLast = cnt == LASTV;
        i0 = cnt[IW-1:0];
        i1 = atLast ? '0 : i0 + IW'(1);
        q1x = sorting ? vx[0] : tx;
        q1y = sorting ? vy[0] : ty;
        q2x = sorting ? vx[0] : vx[i0];
        q2y = sorting ? vy[0] : vy[i0];
        ax = {1'b0, vx[i0]} - {1'b0, q1x};
        ay = {1'b0, vy[i0]} - {1'b0, q1y};
        bx = {1'b0, vx[i1]} - {1'b0, q2x};
        by = {1'b0, vy[i1]} - {1'b0, q2y};
        axe = {{(W-CW-1){ax[CW]}}, ax};
        aye = {{(W-CW-1){ay[CW]}}, ay};
        bxe = {{(W-CW-1){bx[CW]}}, bx};
        bye = {{(W-CW-1){by[CW]}}, by};
        cr = axe * bye - bxe * aye;
        eNeg = cr[W-1];
        eZero = cr == '0;
        swapNow = sorting & ~eNeg;
        passEnd = cnt == LASTS;
        // The pass cap keeps degenerate input (zero crosses swap forever) inside the sort bound.
        again = (swapped | swapNow) & (passCnt != LASTS);
        nNeg = negAll & (eNeg | (eZero & ZERO_OK));
        nPos = posAll & ~eNeg & (~eZero | ZERO_OK);
    end

    always_comb begin
        ready = live & (state == IDLE | state == LOAD);
        valid = state == DONE;
        nextState = state;
        case (state)
            IDLE: nextState = ready ? LOAD : IDLE;
            LOAD: nextState = atLast ? SORT : LOAD;
            SORT: nextState = (passEnd & ~again) ? EVAL : SORT;
            EVAL: nextState = atLast ? DONE : EVAL;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            live <= 1'b0;
        end else begin
            state <= nextState;
            live <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            passCnt <= '0;
            swapped <= 1'b0;
            negAll <= 1'b0;
            posAll <= 1'b0;
            is_inside <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready) begin
                        tx <= X;
                        ty <= Y;
                    end
                end
                LOAD: begin
                    vx[i0] <= X;
                    vy[i0] <= Y;
                    cnt <= atLast ? CNTW'(1) : cnt + CNTW'(1);
                    swapped <= 1'b0;
                    passCnt <= '0;
                end
                SORT: begin
                    if (swapNow) begin
                        vx[i0] <= vx[i1];
                        vx[i1] <= vx[i0];
                        vy[i0] <= vy[i1];
                        vy[i1] <= vy[i0];
                    end
                    swapped <= passEnd ? 1'b0 : swapped | swapNow;
                    passCnt <= passCnt + CNTW'(passEnd & again);
                    cnt <= passEnd ? (again ? CNTW'(1) : '0) : cnt + CNTW'(1);
                    negAll <= 1'b1;
                    posAll <= 1'b1;
                end
                EVAL: begin
                    negAll <= nNeg;
                    posAll <= nPos;
                    cnt <= atLast ? '0 : cnt + CNTW'(1);
                    if (atLast) is_inside <= nNeg | nPos;
                end
                default: ;
            endcase
        end
    end
endmodule
